// File: rtl/sad_accumulator.sv
// sad_accumulator: pipelined sum-of-absolute-differences engine.
// LANES pixel pairs per beat -> per-lane |A-B| (S1) -> lane sum (S2) ->
// saturating block accumulator. A block of BLOCK_LEN beats is presented
// on a valid/ready result port.
// Optional feature: define SAD_MIN_TRACK_EN to track the minimum block SAD
// and its index. Without it, Min_sad/Min_idx are constant 0.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready are both 1. The producer holds its data stable while valid
// is high and not yet accepted. ready never depends combinationally on valid.
module sad_accumulator #(
   parameter int DATA_W    = 8,
   parameter int LANES     = 4,
   parameter int BLOCK_LEN = 16,
   parameter int ACC_W     = 24,
   parameter int IDX_W     = 8
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    Clear,
   input  logic                    In_valid,
   output logic                    In_ready,
   input  logic [LANES*DATA_W-1:0] In_A,
   input  logic [LANES*DATA_W-1:0] In_B,
   output logic                    Out_valid,
   input  logic                    Out_ready,
   output logic [ACC_W-1:0]        Out_sad,
   output logic [IDX_W-1:0]        Out_idx,
   output logic                    Out_sat,
   output logic [ACC_W-1:0]        Min_sad,
   output logic [IDX_W-1:0]        Min_idx,
   output logic [1:0]              Dbg_state
);

   localparam int SUM_W = DATA_W + $clog2(LANES);
   localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 ready_en;
   logic                 accept;
   logic                 beat_last;
   logic                 done_hs;
   logic [CNT_W-1:0]     beat_cnt;
   logic                 drain_q;

   logic [DATA_W-1:0]    diff_d [LANES];
   logic [DATA_W-1:0]    s1_diff [LANES];
   logic                 s1_v;
   logic [SUM_W-1:0]     lane_sum;
   logic [SUM_W-1:0]     s2_sum;
   logic                 s2_v;

   logic [ACC_W:0]       acc_sum;
   logic [ACC_W-1:0]     acc_q;
   logic                 sat_q;
   logic [IDX_W-1:0]     idx_q;

   // ready_en holds In_ready low while in reset and through the first edge after it
   assign accept    = In_valid && ready_en && !Clear &&
                      ((state_q == IDLE) || (state_q == ACCUM));
   assign beat_last = (beat_cnt == CNT_W'(BLOCK_LEN - 1));
   assign done_hs   = (state_q == DONE) && Out_ready && !Clear;
   assign Dbg_state = state_q;

   // Register the input-ready enable so In_ready rises on the first clock after reset
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // FSM state register; Clear forces IDLE
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)     state_q <= IDLE;
      else if (Clear) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d   = state_q;
      In_ready  = 1'b0;
      Out_valid = 1'b0;
      case (state_q)
         IDLE, ACCUM: begin
            In_ready = ready_en;
            if (accept) state_d = beat_last ? DRAIN : ACCUM;
         end
         DRAIN: begin
            if (drain_q) state_d = DONE;
         end
         DONE: begin
            Out_valid = 1'b1;
            if (Out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Beat counter within a block and the two-cycle drain timer
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         beat_cnt <= '0;
         drain_q  <= 1'b0;
      end else if (Clear) begin
         beat_cnt <= '0;
         drain_q  <= 1'b0;
      end else begin
         if (accept) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
         drain_q <= (state_q == DRAIN) && !drain_q;
      end
   end

   // Per-lane unsigned absolute difference of the incoming beat
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         diff_d[i] = (In_B[i*DATA_W +: DATA_W] < In_A[i*DATA_W +: DATA_W]) ?
                     (In_A[i*DATA_W +: DATA_W] - In_B[i*DATA_W +: DATA_W]) :
                     (In_B[i*DATA_W +: DATA_W] - In_A[i*DATA_W +: DATA_W]);
      end
   end

   // Sum of the S1 lane differences; SUM_W is wide enough that it cannot overflow
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SUM_W'(s1_diff[i]);
   end

   // S1 and S2 pipeline registers; only the valids need clearing on abort
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s1_v   <= 1'b0;
         s2_v   <= 1'b0;
         s2_sum <= '0;
         for (int i = 0; i < LANES; i++) s1_diff[i] <= '0;
      end else if (Clear) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= accept;
         s2_v <= s1_v;
         if (accept) begin
            for (int i = 0; i < LANES; i++) s1_diff[i] <= diff_d[i];
         end
         if (s1_v) s2_sum <= lane_sum;
      end
   end

   assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(s2_sum);

   // Saturating accumulator, sticky saturation flag and block index
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         idx_q <= '0;
      end else if (Clear) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         idx_q <= '0;
      end else if (done_hs) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         idx_q <= idx_q + 1'b1;
      end else if (s2_v) begin
         if (acc_sum[ACC_W]) begin
            acc_q <= '1;
            sat_q <= 1'b1;
         end else begin
            acc_q <= acc_sum[ACC_W-1:0];
         end
      end
   end

   assign Out_sad = acc_q;
   assign Out_sat = sat_q;
   assign Out_idx = idx_q;

`ifdef SAD_MIN_TRACK_EN
   logic [ACC_W-1:0] min_sad_q;
   logic [IDX_W-1:0] min_idx_q;

   // Running minimum over consumed blocks; strict compare keeps the earlier index on ties
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         min_sad_q <= '1;
         min_idx_q <= '0;
      end else if (Clear) begin
         min_sad_q <= '1;
         min_idx_q <= '0;
      end else if (done_hs && (acc_q < min_sad_q)) begin
         min_sad_q <= acc_q;
         min_idx_q <= idx_q;
      end
   end

   assign Min_sad = min_sad_q;
   assign Min_idx = min_idx_q;
`else
   assign Min_sad = '0;
   assign Min_idx = '0;
`endif

endmodule

// File: doc/sad_accumulator.md
Name: sad_accumulator

Overview:
- Parametrised, pipelined sum-of-absolute-differences engine for the motion-estimation datapath; successor to the single-pair combinational absolute-difference unit.
- Accepts LANES pixel pairs per beat and computes |A-B| per lane through an adder tree.
- Accumulates BLOCK_LEN beats into one block SAD and presents it on a valid/ready output.
- Optionally tracks the minimum SAD and its block index across a search window.

Parameters:
DATA_W, 8, unsigned width of one pixel
LANES, 4, pixel pairs per input beat (power of two, 1..16)
BLOCK_LEN, 16, beats per block (>=1)
ACC_W, 24, width of block SAD and min registers
IDX_W, 8, width of block index counter

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
Clear  in  1  synchronous abort/restart; highest priority after reset
In_valid  in  1  input beat valid
In_ready  out  1  input beat accepted when In_valid&&In_ready
In_A  in  LANES*DATA_W  packed current pixels, lane i at [i*DATA_W +: DATA_W]
In_B  in  LANES*DATA_W  packed reference pixels, same packing
Out_valid  out  1  block result valid
Out_ready  in  1  result consumed when Out_valid&&Out_ready
Out_sad  out  ACC_W  block SAD
Out_idx  out  IDX_W  index of this block since last Clear/reset
Out_sat  out  1  block SAD saturated
Min_sad  out  ACC_W  running minimum SAD (optional feature)
Min_idx  out  IDX_W  block index of running minimum (optional feature)

Behaviour:
- Reset (Rst_n=0, async): state IDLE; beat counter, block index, accumulator and pipeline valids cleared. Outputs: In_ready=0 while in reset, 1 from first clock after release. Out_valid=0, Out_sad=0, Out_idx=0, Out_sat=0. Min_sad=all-ones, Min_idx=0.
- Per-lane arithmetic: unsigned; |A-B| = (B<A) ? A-B : B-A, DATA_W bits.
- Lane sum width: DATA_W+log2(LANES), no overflow.
- Pipeline:
  - S1 registers per-lane absolute differences.
  - S2 registers the adder-tree sum.
  - Accumulator adds the S2 sum.
- Latency: last beat accepted at cycle t -> Out_valid=1 at t+3.
- Accumulator saturates at 2^ACC_W-1. Sticky Out_sat=1 for that block.
- FSM states:
  - IDLE: In_ready=1. First accepted beat -> ACCUM, beat count=1. If BLOCK_LEN=1, go directly to DRAIN.
  - ACCUM: In_ready=1. Each accepted beat increments count. Accepting beat BLOCK_LEN -> DRAIN.
  - DRAIN: In_ready=0 for 2 cycles while S1/S2 empty into the accumulator -> DONE.
  - DONE: Out_valid=1. Out_sad/Out_idx/Out_sat stable until handshake.
    - On Out_ready: accumulator and Out_sat cleared, block index +1 (wraps modulo 2^IDX_W), -> IDLE.
    - In_ready=0 in DONE: no beat is lost or merged across blocks.
- In_valid=0 mid-block: pipeline bubbles. Accumulation is unaffected and the count does not advance.
- Clear=1:
  - Next edge: state IDLE, counters, accumulator, pipeline valids and block index zeroed. Out_valid drops, Min_sad reset to all-ones, Min_idx to 0.
  - A beat presented in the same cycle as Clear is discarded.
- Reset or Clear mid-block: partial block discarded. No Out_valid is generated for it.

Optional Feature:
- Macro: SAD_MIN_TRACK_EN.
- Defined: on each output handshake, if Out_sad < Min_sad (strict), Min_sad<=Out_sad and Min_idx<=Out_idx. Ties keep the earlier index. Updated values are visible the cycle after the handshake.
- Undefined: no comparator or min registers; Min_sad and Min_idx are driven constant 0.

Test Plan:
- Defaults, 16 beats with all lanes A=200,B=50 -> Out_sad=16*4*150=9600, Out_sat=0, Out_idx=0; Out_valid 3 cycles after last beat.
- Lanes A={10,250,0,255}, B={20,5,255,0} each beat, 16 beats -> per-beat sum 10+245+255+255=765, Out_sad=12240. Swapping A/B gives identical result.
- ACC_W=12, all lanes A=255,B=0, 16 beats -> Out_sad=4095, Out_sat=1. Next block of zeros -> Out_sad=0, Out_sat=0.
- Out_ready held 0 for 10 cycles in DONE with In_valid=1 -> In_ready=0 throughout and Out_sad stable. Release -> next block accepted and correct, Out_idx=1.
- Clear asserted after 7 beats of a block -> no Out_valid. Next full block of A=1,B=0 -> Out_sad=64, Out_idx=0.
- SAD_MIN_TRACK_EN defined, blocks with SAD 500, 300, 300, 800 -> Min_sad=300, Min_idx=1. Undefined -> Min_sad=Min_idx=0.
